// File: rtl/sequence_detector_pkg.sv
// ----------------------------------------------------------------------------
// sequence_detector_pkg
//   Shared definitions for the serial "1011" sequence detector.
//   - state_e : FSM state encoding (2-bit), one state per matched prefix length
//   - PATTERN : the detected bit pattern, first-received bit in the MSB
// ----------------------------------------------------------------------------
package sequence_detector_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,   // no useful prefix seen
        S_1    = 2'b01,   // seen "1"
        S_10   = 2'b10,   // seen "10"
        S_101  = 2'b11    // seen "101"
    } state_e;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/sequence_detector_fsm.sv
// ----------------------------------------------------------------------------
// sequence_detector_fsm
//   Mealy FSM that flags the serial bit pattern 1011 on input X.
//
//   Parameters
//     OVERLAP : 1 = overlapping detection (the trailing "1" of a match can
//               start the next match), 0 = restart from idle after a match.
//   Ports
//     Clk   in  1  clock, state updates on the rising edge
//     Rst_n in  1  asynchronous active-low reset, forces S_IDLE
//     X     in  1  serial data bit, consumed on each rising edge
//     Y     out 1  high while the current X completes the pattern
// ----------------------------------------------------------------------------
module sequence_detector_fsm
    import sequence_detector_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic X,
    output logic Y
);

    state_e state_q;
    state_e state_d;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: state_d = X ? S_1 : S_IDLE;
            S_1:    state_d = X ? S_1 : S_10;
            S_10:   state_d = X ? S_101 : S_IDLE;
            S_101: begin
                if (!X) begin
                    // "1010": the trailing "10" is itself a valid prefix
                    state_d = S_10;
                end else if (OVERLAP != 0) begin
                    // the final "1" of the match seeds the next search
                    state_d = S_1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Mealy output: the match completes when the last pattern bit arrives
    // while the "101" prefix is held.
    always_comb begin
        Y = 1'b0;
        if (state_q == S_101 && X == PATTERN[0]) begin
            Y = 1'b1;
        end
    end

endmodule

// File: tb/tb_sequence_detector_fsm.sv
// ----------------------------------------------------------------------------
// tb_sequence_detector_fsm
//   Directed testbench for sequence_detector_fsm. Two instances share clock,
//   reset and data: one overlapping, one non-overlapping.
// ----------------------------------------------------------------------------
module tb_sequence_detector_fsm;

    logic Clk = 1'b0;
    logic Rst_n;
    logic X;
    logic y_ov;
    logic y_no;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    sequence_detector_fsm #(.OVERLAP(1)) dut_ov (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .X     (X),
        .Y     (y_ov)
    );

    sequence_detector_fsm #(.OVERLAP(0)) dut_no (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .X     (X),
        .Y     (y_no)
    );

    // Drive one bit on the falling edge and sample both outputs before the
    // rising edge that consumes it.
    task automatic drive_bit(input logic x, output logic yo, output logic yn);
        @(negedge Clk);
        X = x;
        #2;
        yo = y_ov;
        yn = y_no;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        X     = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        X     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            X = 1'b1;
            #2;
            checks++;
            if (y_ov !== 1'b0 || y_no !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: y_ov=%b y_no=%b required 0/0", i, y_ov, y_no);
            end
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        X     = 1'b0;
    endtask

    task automatic test_basic();
        logic [0:3] bits;
        logic [0:3] exp;
        logic yo, yn;
        bits = 4'b1011;
        exp  = 4'b0001;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_bit(bits[i], yo, yn);
            checks++;
            if (yo !== exp[i] || yn !== exp[i]) begin
                errors++;
                $display("FAIL basic bit%0d: y_ov=%b y_no=%b required %b", i + 1, yo, yn, exp[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [0:6] bits;
        logic [0:6] exp_ov;
        logic [0:6] exp_no;
        logic yo, yn;
        bits   = 7'b1011011;
        exp_ov = 7'b0001001;
        exp_no = 7'b0001000;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive_bit(bits[i], yo, yn);
            checks++;
            if (yo !== exp_ov[i]) begin
                errors++;
                $display("FAIL overlap_ov bit%0d: y=%b required %b", i + 1, yo, exp_ov[i]);
            end
            checks++;
            if (yn !== exp_no[i]) begin
                errors++;
                $display("FAIL overlap_no bit%0d: y=%b required %b", i + 1, yn, exp_no[i]);
            end
        end
    endtask

    task automatic test_long_stream();
        logic [0:15] bits;
        logic [0:15] exp;
        logic yo, yn;
        bits = 16'b1101_1101_0110_0101;
        exp  = 16'b0000_1000_0010_0000;   // positions 5 and 11
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive_bit(bits[i], yo, yn);
            checks++;
            if (yo !== exp[i]) begin
                errors++;
                $display("FAIL long_ov bit%0d: y=%b required %b", i + 1, yo, exp[i]);
            end
            checks++;
            if (yn !== exp[i]) begin
                errors++;
                $display("FAIL long_no bit%0d: y=%b required %b", i + 1, yn, exp[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [0:2] pre;
        logic [0:2] post;
        logic [0:2] exp_post;
        logic yo, yn;
        pre      = 3'b101;
        post     = 3'b011;
        exp_post = 3'b001;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_bit(pre[i], yo, yn);
            checks++;
            if (yo !== 1'b0 || yn !== 1'b0) begin
                errors++;
                $display("FAIL midrst_pre bit%0d: y_ov=%b y_no=%b required 0/0", i + 1, yo, yn);
            end
        end
        // Both FSMs now hold "101"; pulse reset between edges, then present 1.
        @(negedge Clk);
        X = 1'b0;
        #1 Rst_n = 1'b0;
        #1;
        checks++;
        if (y_ov !== 1'b0 || y_no !== 1'b0) begin
            errors++;
            $display("FAIL midrst_low: y_ov=%b y_no=%b required 0/0", y_ov, y_no);
        end
        Rst_n = 1'b1;
        #1 X = 1'b1;
        #1;
        checks++;
        if (y_ov !== 1'b0 || y_no !== 1'b0) begin
            errors++;
            $display("FAIL midrst_x1: y_ov=%b y_no=%b required 0/0", y_ov, y_no);
        end
        // That edge should have moved to S_1: 0,1,1 then completes 1011.
        for (int i = 0; i < 3; i++) begin
            drive_bit(post[i], yo, yn);
            checks++;
            if (yo !== exp_post[i] || yn !== exp_post[i]) begin
                errors++;
                $display("FAIL midrst_post bit%0d: y_ov=%b y_no=%b required %b",
                         i + 1, yo, yn, exp_post[i]);
            end
        end
    endtask

    task automatic test_constant_streams();
        logic yo, yn;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive_bit(1'b0, yo, yn);
            checks++;
            if (yo !== 1'b0 || yn !== 1'b0) begin
                errors++;
                $display("FAIL zeros bit%0d: y_ov=%b y_no=%b required 0/0", i + 1, yo, yn);
            end
        end
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive_bit(1'b1, yo, yn);
            checks++;
            if (yo !== 1'b0 || yn !== 1'b0) begin
                errors++;
                $display("FAIL ones bit%0d: y_ov=%b y_no=%b required 0/0", i + 1, yo, yn);
            end
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        X     = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_long_stream();
        test_midstream_reset();
        test_constant_streams();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
